// File: rtl/rom_bridge_mapper.sv
// rom_bridge_mapper
//
// Cartridge ROM front-end that sits between the HPS download port, the ROM
// memory controller and the console core.
//  - Download path: each ioctl write becomes a toggle-handshaked write command
//    to the memory controller. ioctl_wait stalls the host until the command is
//    acknowledged. A write that arrives while a command is still pending is
//    dropped and raises the sticky overrun flag.
//  - Size tracking: the highest written address of a download is turned into
//    a power-of-two mirror mask (rom_mask) when the download window closes.
//  - Read path: CPU word addresses are mapped either through an SSF2-style
//    bank register file (once the core has written a bank register) or
//    mirrored by rom_mask. The result is registered into rd_addr.
//
// Ports
//   clk_sys         single system clock
//   reset           synchronous, active-high core reset
//   ioctl_download  download window active
//   ioctl_wr        one-cycle write strobe from the host
//   ioctl_addr      byte address of the host write
//   ioctl_dout      host write data
//   ioctl_wait      stall request back to the host
//   wr_addr/wr_data write command to the memory controller
//   wr_req          toggle request; a command is pending while wr_req != wr_ack
//   wr_ack          toggle acknowledge from the memory controller
//   overrun         sticky flag: a host write was dropped while busy
//   map_we/a/d      bank register write from the core (entry 0 is fixed)
//   cpu_addr        CPU word address (bank select in the top BA bits)
//   rd_addr         registered physical word address
//   use_map         bank mapper engaged
//   rom_mask        word-address mirror mask of the loaded image
module rom_bridge_mapper #(
  parameter int  AW        = 25,
  parameter int  DW        = 16,
  parameter int  SWAP      = 1,
  parameter int  BANKS     = 8,
  parameter int  BANK_BITS = 6,
  parameter int  PAGE_BITS = 19,
  localparam int BA        = $clog2(BANKS),
  localparam int RW        = PAGE_BITS + BANK_BITS
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [AW-1:0]           ioctl_addr,
  input  logic [DW-1:0]           ioctl_dout,
  output logic                    ioctl_wait,
  output logic [AW-1:0]           wr_addr,
  output logic [DW-1:0]           wr_data,
  output logic                    wr_req,
  input  logic                    wr_ack,
  output logic                    overrun,
  input  logic                    map_we,
  input  logic [BA-1:0]           map_a,
  input  logic [BANK_BITS-1:0]    map_d,
  input  logic [PAGE_BITS+BA-1:1] cpu_addr,
  output logic [RW-1:1]           rd_addr,
  output logic                    use_map,
  output logic [RW-1:1]           rom_mask
);

  localparam int CW = RW - 1;  // width of a physical word address

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state;
  logic                 wr_req_q;
  logic                 overrun_q;
  logic [AW-1:0]        wr_addr_q;
  logic [DW-1:0]        wr_data_q;
  logic [AW-1:1]        max_addr;   // highest written word index of the download
  logic                 seen;       // at least one write accepted this download
  logic                 dl_q;
  logic                 dl_q2;
  logic                 dl_rise;
  logic                 dl_fall;
  logic [DW-1:0]        din_sw;
  logic [RW-1:1]        mask_next;
  // Kept complemented so that the register's power-up value of zero reads
  // as an all-ones (full address space) mask before any image is loaded.
  logic [RW-1:1]        rom_mask_n;
  logic [BANK_BITS-1:0] bank_map [BANKS];
  logic [BA-1:0]        cpu_bank;
  logic [RW-1:1]        cpu_ext;

  // ---------------------------------------------------------------------------
  // Download data byte order
  // ---------------------------------------------------------------------------
  generate
    if (DW == 16 && SWAP != 0) begin : g_swap
      assign din_sw = {ioctl_dout[7:0], ioctl_dout[15:8]};
    end else begin : g_noswap
      assign din_sw = ioctl_dout;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Download window edge detection. The edges are taken from the registered
  // copy of ioctl_download so both edges are acted on one cycle late.
  // ---------------------------------------------------------------------------
  assign dl_rise = dl_q & ~dl_q2;
  assign dl_fall = ~dl_q & dl_q2;

  // ---------------------------------------------------------------------------
  // Write FSM. wr_req, the write command, overrun and the size tracker are
  // deliberately outside the reset: the toggle pairing with the memory
  // controller and the loaded image must survive a core reset. They rely on
  // the power-up-to-zero of the FPGA registers instead.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      ioctl_wait <= 1'b0;
    end else if (dl_rise) begin
      // Re-pair the toggle and start a fresh download; a write in this same
      // cycle is intentionally ignored.
      state      <= IDLE;
      ioctl_wait <= 1'b0;
      wr_req_q   <= wr_ack;
      overrun_q  <= 1'b0;
      max_addr   <= '0;
      seen       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The ack is not examined here, so a stale ack left over from a
          // reset during BUSY is simply absorbed.
          if (ioctl_wr) begin
            wr_addr_q  <= ioctl_addr;
            wr_data_q  <= din_sw;
            wr_req_q   <= ~wr_req_q;
            ioctl_wait <= 1'b1;
            state      <= BUSY;
            seen       <= 1'b1;
            if (ioctl_addr[AW-1:1] > max_addr) max_addr <= ioctl_addr[AW-1:1];
          end
        end
        BUSY: begin
          if (wr_req_q == wr_ack) begin
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end
          if (ioctl_wr) overrun_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign overrun = overrun_q;

  // ---------------------------------------------------------------------------
  // Mirror mask: bit k of the word mask is set when any byte-address bit at or
  // above k is set in the highest written address.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mask_next = '0;
    for (int k = 1; k < RW; k++) begin
      mask_next[k] = |(max_addr >> (k - 1));
    end
  end

  always_ff @(posedge clk_sys) begin
    dl_q  <= ioctl_download;
    dl_q2 <= dl_q;
    // An empty download leaves the previous image's mask in place.
    if (dl_fall && seen) rom_mask_n <= ~mask_next;
  end

  assign rom_mask = ~rom_mask_n;

  // ---------------------------------------------------------------------------
  // Bank register file. Entry 0 is hard-wired to page 0.
  // ---------------------------------------------------------------------------
  // NOTE: this register file is built from flops, so it takes a reset to the
  // identity map; a block-RAM backed table could not be reset this way.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < BANKS; i++) bank_map[i] <= BANK_BITS'(i);
      use_map <= 1'b0;
    end else if (map_we && map_a != '0) begin
      bank_map[map_a] <= map_d;
      use_map         <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address translation (one cycle latency)
  // ---------------------------------------------------------------------------
  assign cpu_bank = cpu_addr[PAGE_BITS+BA-1:PAGE_BITS];
  assign cpu_ext  = CW'(cpu_addr);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (use_map) begin
      rd_addr <= {bank_map[cpu_bank], cpu_addr[PAGE_BITS-1:1]};
    end else begin
      rd_addr <= cpu_ext & rom_mask;
    end
  end

endmodule

// File: tb/tb_rom_bridge_mapper.sv
// Directed-plus-random bench for rom_bridge_mapper. Expected values come from
// a small behavioural model: a toggle bit, the highest written address, a
// power-of-two mask computed arithmetically, and an integer bank table.
module tb_rom_bridge_mapper;

  localparam int AW         = 25;
  localparam int DW         = 16;
  localparam int BANKS      = 8;
  localparam int BA         = 3;
  localparam int BANK_BITS  = 6;
  localparam int PAGE_BITS  = 19;
  localparam int RW         = PAGE_BITS + BANK_BITS;
  localparam int PAGE_WORDS = 1 << (PAGE_BITS - 1);

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic                    ioctl_download;
  logic                    ioctl_wr;
  logic [AW-1:0]           ioctl_addr;
  logic [DW-1:0]           ioctl_dout;
  logic                    ioctl_wait;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    wr_req;
  logic                    wr_ack;
  logic                    overrun;
  logic                    map_we;
  logic [BA-1:0]           map_a;
  logic [BANK_BITS-1:0]    map_d;
  logic [PAGE_BITS+BA-1:1] cpu_addr;
  logic [RW-1:1]           rd_addr;
  logic                    use_map;
  logic [RW-1:1]           rom_mask;

  rom_bridge_mapper #(
    .AW(AW), .DW(DW), .SWAP(1), .BANKS(BANKS),
    .BANK_BITS(BANK_BITS), .PAGE_BITS(PAGE_BITS)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .overrun        (overrun),
    .map_we         (map_we),
    .map_a          (map_a),
    .map_d          (map_d),
    .cpu_addr       (cpu_addr),
    .rd_addr        (rd_addr),
    .use_map        (use_map),
    .rom_mask       (rom_mask)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic        m_req  = 1'b0;
  int unsigned m_max  = 0;
  bit          m_seen = 0;
  int unsigned m_mask = 32'h00FF_FFFF;
  int unsigned m_map [BANKS];
  bit          m_use  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] f_swap(input logic [15:0] d);
    return 16'(((d & 16'h00FF) << 8) | (d >> 8));
  endfunction

  // Word mirror mask: all word-index bits below the MSB of the byte address.
  function automatic int unsigned f_mask(input int unsigned max_byte);
    int n = 0;
    while ((max_byte >> (n + 1)) != 0) n++;
    return ((32'd1 << (n + 1)) - 1) >> 1;
  endfunction

  function automatic int unsigned f_rd(input int unsigned cpu);
    if (m_use) return m_map[cpu / PAGE_WORDS] * PAGE_WORDS + (cpu % PAGE_WORDS);
    return cpu & m_mask;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < BANKS; i++) m_map[i] = i;
    m_use = 0;
  endtask

  // Accepted host write followed by an ack after `delay` cycles.
  task automatic host_write(input string tag, input int unsigned addr,
                            input logic [15:0] data, input int delay);
    ioctl_addr = AW'(addr);
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    m_req      = ~m_req;
    m_seen     = 1;
    if (addr > m_max) m_max = addr;
    check({tag, "_addr"}, wr_addr, addr);
    check({tag, "_data"}, wr_data, f_swap(data));
    check({tag, "_req"},  wr_req, m_req);
    check({tag, "_wait"}, ioctl_wait, 1'b1);
    repeat (delay) tick();
    wr_ack = m_req;
    tick();
    check({tag, "_wait_rel"}, ioctl_wait, 1'b0);
  endtask

  task automatic map_write(input int a, input int d);
    map_a  = BA'(a);
    map_d  = BANK_BITS'(d);
    map_we = 1'b1;
    tick();
    map_we = 1'b0;
    if (a != 0) begin
      m_map[a] = d;
      m_use    = 1;
    end
  endtask

  task automatic cpu_read(input string tag, input int unsigned cpu);
    cpu_addr = (PAGE_BITS + BA - 1)'(cpu);
    tick();
    check(tag, rd_addr, f_rd(cpu));
  endtask

  task automatic download_start;
    ioctl_download = 1'b1;
    repeat (3) tick();
    m_req  = wr_ack;
    m_max  = 0;
    m_seen = 0;
  endtask

  initial begin
    int unsigned a;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    wr_ack         = 1'b0;
    map_we         = 1'b0;
    map_a          = '0;
    map_d          = '0;
    cpu_addr       = '0;
    model_reset();

    // Power-up and reset state
    tick();
    check("pwrup_mask",    rom_mask, 24'hFF_FFFF);
    check("pwrup_req",     wr_req, 1'b0);
    check("pwrup_overrun", overrun, 1'b0);
    tick();
    reset = 1'b0;
    check("rst_wait",    ioctl_wait, 1'b0);
    check("rst_use_map", use_map, 1'b0);
    check("rst_rd_addr", rd_addr, 24'h0);

    // Write path with byte swap, ack five cycles later
    download_start();
    host_write("wr1", 32'h10, 16'h1234, 4);

    // Overrun: second write while busy is dropped
    ioctl_addr = AW'(32'h20);
    ioctl_dout = 16'hABCD;
    ioctl_wr   = 1'b1;
    tick();
    m_req  = ~m_req;
    m_seen = 1;
    if (32'h20 > m_max) m_max = 32'h20;
    ioctl_addr = AW'(32'h30);
    ioctl_dout = 16'h5555;
    tick();
    ioctl_wr = 1'b0;
    check("ovr_flag",  overrun, 1'b1);
    check("ovr_req",   wr_req, m_req);
    check("ovr_addr",  wr_addr, 25'h20);
    check("ovr_data",  wr_data, 16'hCDAB);
    wr_ack = m_req;
    tick();
    check("ovr_wait_rel", ioctl_wait, 1'b0);

    // Random image body, then the last word of a 384 KB image
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 32'h5FFFC) & ~32'h1;
      host_write("rnd_wr", a, 16'($urandom), int'($urandom_range(0, 3)));
    end
    host_write("last_wr", 32'h5FFFE, 16'($urandom), 0);
    check("ovr_sticky", overrun, 1'b1);

    // Mask appears two cycles after the download closes
    ioctl_download = 1'b0;
    tick();
    check("mask_lat1", rom_mask, 24'hFF_FFFF);
    tick();
    if (m_seen) m_mask = f_mask(m_max);
    check("mask_384k", rom_mask, 24'h03_FFFF);

    // Mirroring
    cpu_read("mirror_top",  32'h40000);
    check("mirror_top_zero", rd_addr, 24'h0);
    cpu_read("mirror_last", 32'h3FFFF);
    for (int i = 0; i < 8; i++) cpu_read("mirror_rnd", $urandom_range(0, (1 << 21) - 1));

    // New download clears overrun; an empty download keeps the mask
    download_start();
    check("ovr_clear", overrun, 1'b0);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("empty_dl_mask", rom_mask, 24'h03_FFFF);

    // Mapper
    map_write(7, 8'h0A);
    check("map_use", use_map, 1'b1);
    cpu_read("map7", 32'h1C0000);
    check("map7_abs", rd_addr, 24'h28_0000);
    map_write(0, 5);
    cpu_read("map0_fixed", 32'h123);
    for (int i = 0; i < 8; i++) begin
      map_write(int'($urandom_range(0, BANKS - 1)), int'($urandom_range(0, 63)));
      cpu_read("map_rnd", $urandom_range(0, (1 << 21) - 1));
    end

    // Reset while a write is pending
    ioctl_addr = AW'(32'h100);
    ioctl_dout = 16'h5566;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    m_req    = ~m_req;
    check("rbusy_wait", ioctl_wait, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("rbusy_wait_drop", ioctl_wait, 1'b0);
    check("rbusy_use_map",   use_map, 1'b0);
    check("rbusy_mask",      rom_mask, 24'h03_FFFF);
    check("rbusy_req",       wr_req, m_req);
    map_write(1, 1);
    cpu_read("rbusy_identity", 32'h1C0155);
    wr_ack = m_req;  // late ack absorbed in IDLE
    tick();
    host_write("after_rst", 32'h200, 16'h7788, 1);

    // Reset wins over a simultaneous bank write
    reset  = 1'b1;
    map_a  = BA'(3);
    map_d  = BANK_BITS'(6'h3F);
    map_we = 1'b1;
    tick();
    reset  = 1'b0;
    map_we = 1'b0;
    model_reset();
    check("rst_prio_use", use_map, 1'b0);
    map_write(1, 1);
    cpu_read("rst_prio_map3", 32'h0C0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
